// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and width helpers for the parametrised FIFO.
//   FIFO_DATA_W / FIFO_DEPTH       default word width and entry count
//   FIFO_AF_LEVEL / FIFO_AE_LEVEL  default almost-full / almost-empty levels
//   cnt_width()                    width of an occupancy count (0..depth)
package fifo_pkg;

    localparam int unsigned FIFO_DATA_W   = 32;
    localparam int unsigned FIFO_DEPTH    = 32;
    localparam int unsigned FIFO_AF_LEVEL = 28;
    localparam int unsigned FIFO_AE_LEVEL = 4;

    // Occupancy must reach DEPTH itself, so it needs one bit more than a pointer.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: DEPTH x DATA_W register-array storage for fifo_param.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset (clears the read register only)
//   we/waddr/wdata  write port
//   re/raddr     read request and address
//   rdata_q      registered read data, loaded from raddr when re is high
//   rdata_c      combinational read data at raddr
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W = FIFO_DATA_W,
    parameter int unsigned DEPTH  = FIFO_DEPTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata_q,
    output logic [DATA_W-1:0] rdata_c
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read-before-write: a read and write to the same slot return the old word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// fifo_param: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty levels and sticky overflow/underflow flags.
// Build option: define FIFO_FWFT_EN for first-word-fall-through output;
// otherwise data_out is valid one cycle after an accepted read.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   wr_en, data_in        write request and data
//   rd_en                 read request (pop)
//   data_out, data_valid  read data and its valid strobe
//   full, empty, almost_full, almost_empty, count   occupancy status
//   clr_err               clears overflow/underflow
//   overflow, underflow   sticky error flags
module fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_W   = FIFO_DATA_W,
    parameter int unsigned DEPTH    = FIFO_DEPTH,
    parameter int unsigned AF_LEVEL = FIFO_AF_LEVEL,
    parameter int unsigned AE_LEVEL = FIFO_AE_LEVEL,
    localparam int unsigned ADDR_W  = $clog2(DEPTH),
    localparam int unsigned CNT_W   = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    input  logic              clr_err,
    output logic              overflow,
    output logic              underflow
);

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count_nxt;
    logic              rd_accept;
    logic              wr_accept;
    logic              ovf_set;
    logic              udf_set;
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] ram_c;

    always_comb begin
        rd_accept = rd_en && !empty;
        // A pop in the same cycle frees the slot, so a full FIFO still takes the write.
        wr_accept = wr_en && (!full || rd_accept);
        ovf_set   = wr_en && full && !rd_accept;
        udf_set   = rd_en && empty;
        unique case ({wr_accept, rd_accept})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            count        <= count_nxt;
            // Flags come from the next count so they line up with count itself.
            empty        <= (count_nxt == '0);
            full         <= (count_nxt == CNT_W'(DEPTH));
            almost_empty <= (count_nxt <= CNT_W'(AE_LEVEL));
            almost_full  <= (count_nxt >= CNT_W'(AF_LEVEL));
            // A new error event wins over a coincident clear.
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (udf_set) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we      (wr_accept && !rst),
        .waddr   (wr_ptr),
        .wdata   (data_in),
        .re      (rd_accept),
        .raddr   (rd_ptr),
        .rdata_q (ram_q),
        .rdata_c (ram_c)
    );

`ifdef FIFO_FWFT_EN
    logic unused_ram_q;
    assign unused_ram_q = ^ram_q;

    // Head entry is always on the combinational port; the pop edge advances rd_ptr.
    assign data_out   = ram_c;
    assign data_valid = !empty;
`else
    logic unused_ram_c;
    logic dv_q;
    assign unused_ram_c = ^ram_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            dv_q <= 1'b0;
        end else begin
            dv_q <= rd_accept;
        end
    end

    assign data_out   = ram_q;
    assign data_valid = dv_q;
`endif

endmodule

// File: tb/tb_fifo_param.sv
module tb_fifo_param;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AF    = 28;
    localparam int unsigned AE    = 4;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] data_in;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [5:0]    count;
    logic          clr_err;
    logic          overflow;
    logic          underflow;

    fifo_param #(
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF),
        .AE_LEVEL (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .clr_err      (clr_err),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] q[$];
    int mc = 0;
    logic [DW-1:0] last_dout = '0;

    typedef struct {
        logic          wr;
        logic          rd;
        logic          clr;
        logic [DW-1:0] din;
        int            exp_cnt;
        logic          exp_empty;
        logic          exp_ovf;
        logic          exp_udf;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; scoreboard tracks stored words and expected occupancy.
    task automatic step(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
        logic ra;
        logic wa;
        logic [DW-1:0] popped;
        ra = r && (mc > 0);
        wa = w && ((mc < int'(DEPTH)) || ra);
        wr_en = w;
        rd_en = r;
        clr_err = c;
        data_in = d;
`ifdef FIFO_FWFT_EN
        chk("fwft_valid", 32'(data_valid), 32'(mc > 0));
        if (mc > 0) chk("fwft_head", data_out, q[0]);
`endif
        popped = '0;
        if (ra) popped = q.pop_front();
        if (wa) q.push_back(d);
        mc = mc + (wa ? 1 : 0) - (ra ? 1 : 0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr_err = 1'b0;
`ifndef FIFO_FWFT_EN
        if (ra) begin
            chk("rd_data", data_out, popped);
            chk("rd_valid", 32'(data_valid), 32'd1);
            last_dout = popped;
        end else begin
            chk("hold_data", data_out, last_dout);
            chk("idle_valid", 32'(data_valid), 32'd0);
        end
`endif
        chk("count", 32'(count), 32'(mc));
        chk("full", 32'(full), 32'(mc == int'(DEPTH)));
        chk("empty", 32'(empty), 32'(mc == 0));
        chk("almost_full", 32'(almost_full), 32'(mc >= int'(AF)));
        chk("almost_empty", 32'(almost_empty), 32'(mc <= int'(AE)));
    endtask

    // Reset with write/read requests active to confirm reset overrides them.
    task automatic do_reset();
        rst = 1'b1;
        wr_en = 1'b1;
        rd_en = 1'b1;
        data_in = '1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        q.delete();
        mc = 0;
        last_dout = '0;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ae", 32'(almost_empty), 32'd1);
        chk("rst_af", 32'(almost_full), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_udf", 32'(underflow), 32'd0);
`ifndef FIFO_FWFT_EN
        chk("rst_dout", data_out, 32'd0);
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        clr_err = 1'b0;
        data_in = '0;

        //             wr    rd    clr   din            cnt empty ovf  udf
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,         0, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 32'h0,         0, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0000_00A5, 1, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'h0,         0, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h0,         0, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h0,         0, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0011, 1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0022, 2, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0033, 2, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h0,         1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0,         0, 1'b1, 1'b0, 1'b0};

        do_reset();

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].din);
            chk("tbl_count", 32'(count), 32'(tbl[i].exp_cnt));
            chk("tbl_empty", 32'(empty), 32'(tbl[i].exp_empty));
            chk("tbl_ovf", 32'(overflow), 32'(tbl[i].exp_ovf));
            chk("tbl_udf", 32'(underflow), 32'(tbl[i].exp_udf));
        end

        // Fill 1..32 from reset.
        do_reset();
        for (int i = 1; i <= 32; i++) begin
            step(1'b1, 1'b0, 1'b0, DW'(i));
        end
        chk("fill_full", 32'(full), 32'd1);

        // Write while full: rejected, sticky overflow, then cleared.
        step(1'b1, 1'b0, 1'b0, 32'hDEAD_0000);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd32);
        step(1'b0, 1'b0, 1'b1, 32'h0);
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Simultaneous read/write while full: head 1 popped, 0x55 queued last.
        step(1'b1, 1'b1, 1'b0, 32'h0000_0055);
        chk("full_rw_ovf", 32'(overflow), 32'd0);
        chk("full_rw_full", 32'(full), 32'd1);

        // Drain: 2..32 then 0x55.
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
        end
`ifndef FIFO_FWFT_EN
        chk("last_word", data_out, 32'h0000_0055);
`endif
        chk("drain_udf", 32'(underflow), 32'd0);
        chk("drain_empty", 32'(empty), 32'd1);

        // Interleaved pairs spanning a pointer wrap.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h1000_0000 + DW'(i));
            step(1'b0, 1'b1, 1'b0, 32'h0);
        end

        // Mid-stream reset with pending data and a set error flag.
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("pre_rst_udf", 32'(underflow), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h2000_0000 + DW'(i));
        end
        do_reset();
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("post_rst_udf", 32'(underflow), 32'd1);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0077);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        chk("post_rst_empty", 32'(empty), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_param.md
Name: fifo_param

Overview:
- Parametrised synchronous FIFO; next generation of the team's fixed 32x32 FIFO.
- Configurable data width and depth, programmable almost-full/almost-empty levels, occupancy count and a read-valid strobe.
- Sticky overflow/underflow error flags with explicit clear.
- Sits between single-clock producer/consumer stages as the standard buffering primitive.

Parameters:
- DATA_W, 32, data word width in bits (>=1)
- DEPTH, 32, number of entries; power of two, >=4
- AF_LEVEL, 28, almost_full asserts when count >= AF_LEVEL (1..DEPTH-1)
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-2, < AF_LEVEL)
- ADDR_W, $clog2(DEPTH), localparam pointer width; count is ADDR_W+1 bits

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  write request
- data_in  in  DATA_W  write data
- rd_en  in  1  read request
- data_out  out  DATA_W  read data
- data_valid  out  1  data_out holds a newly popped word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- count  out  ADDR_W+1  current occupancy, 0..DEPTH
- clr_err  in  1  clears overflow/underflow
- overflow  out  1  sticky: write attempted while full and not accepted
- underflow  out  1  sticky: read attempted while empty

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst. rst sampled on the rising edge of clk and overrides all other inputs.
- Reset values: wr/rd pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, data_out 0, data_valid 0, overflow 0, underflow 0. Memory contents not reset.
- Mid-operation reset discards all stored data. The first cycle after reset behaves as an empty FIFO.
- Write accepted when wr_en && (!full || rd_accept). Stores data_in at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap).
- Read accepted (rd_accept) when rd_en && !empty. rd_ptr increments modulo DEPTH.
- Standard mode read latency 1: on accepted read at edge N, data_out = head word and data_valid = 1 after edge N, for one cycle.
- data_out holds its last value when no read is accepted; data_valid = 0.
- count next value:
  - +1 on write only
  - -1 on read only
  - unchanged on both or neither
- All flags are registered and derived from next-state count, so they are valid in the same cycle as count.
- Full with simultaneous wr_en && rd_en: both accepted; count stays DEPTH; full stays 1; no overflow.
- Empty with simultaneous wr_en && rd_en: write accepted, read rejected, underflow set, count -> 1.
- Rejected write (wr_en && full && !rd_accept): overflow <= 1; data and pointers untouched.
- Rejected read (rd_en && empty): underflow <= 1; data_valid 0; data_out unchanged.
- overflow/underflow stay set until clr_err. If clr_err coincides with a new error event, the flag stays 1 (set wins).

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_out continuously presents the head entry whenever !empty.
  - data_valid = !empty.
  - rd_en acknowledges/pops the head. The next head appears after the popping edge.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge.
  - data_out is don't-care while empty.
- Undefined: standard 1-cycle read latency as above.
- Counts, flags and error rules are identical in both modes.

Decomposition:
- Package fifo_pkg holds:
  - default DATA_W/DEPTH
  - default AF_LEVEL/AE_LEVEL
  - width helper for count (ADDR_W+1)
- One sub-module, fifo_ram: DEPTH x DATA_W register array with write port (we, waddr, wdata), registered read port and combinational read port (the latter used in FWFT).
- Pointers, count, flags and error logic stay in fifo_param.

Test Plan:
- Reset then write 1..32 on consecutive cycles:
  - count reaches 32
  - almost_full rises when count becomes 28
  - full rises after the 32nd write
  - empty falls after the first write
- Read 32 times from full:
  - data_out sequence 1..32, data_valid high each cycle after each pop
  - almost_empty rises at count 4, empty at 0
  - no underflow
- Write 0xDEAD0000 while full:
  - overflow sets, count stays 32, subsequent read order unchanged
  - clr_err clears overflow next cycle
- Simultaneous wr_en/rd_en while full (data 0x55):
  - count stays 32, full stays 1, head popped, 0x55 is later read last
- Simultaneous rd_en/wr_en while empty (data 0xA5):
  - underflow sets, count = 1, next read returns 0xA5
- Wrap: 40 interleaved write/read pairs with DEPTH=32:
  - data matches scoreboard across pointer wrap
  - assert rst mid-stream: count 0, empty 1, all flags reset next cycle
  - repeat with FIFO_FWFT_EN defined and check head visible without rd_en
